// File: rtl/stereo_pkg.sv
// -----------------------------------------------------------------------------
// stereo_pkg
// Shared definitions for the stereo AXI4-Stream framer:
//   - state_e      : framer FSM states
//   - cnt_width()  : width of the beat (x) and line (y) counters,
//                    $clog2 of beats-per-line / HEIGHT, never below 1 bit
//   - stats widths and the err_count saturation value
// -----------------------------------------------------------------------------
package stereo_pkg;

   typedef enum logic [0:0] {
      StWaitSof,
      StActive
   } state_e;

   localparam int unsigned FrameCountW = 16;
   localparam int unsigned ErrCountW   = 8;
   localparam logic [ErrCountW-1:0] ErrSat = 8'd255;

   // A counter over n positions needs $clog2(n) bits; a 1-position counter still
   // needs one bit so the vector stays legal.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stereo_axis_skid.sv
// -----------------------------------------------------------------------------
// stereo_axis_skid
// Two-entry registered output buffer for an AXI4-Stream carrying data, tuser
// and tlast. The head entry drives the outputs directly from flops, so a beat
// accepted on one edge is presented on the next cycle. in_ready_o is low only
// while both entries hold data (and while rst_i is asserted).
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   in_data_i / in_valid_i /  upstream beat; in_ready_o = not full
//   in_user_i / in_last_i
//   out_data_o / out_valid_o  downstream beat, held stable while stalled
//   out_user_o / out_last_o
//   out_ready_i               downstream ready
// -----------------------------------------------------------------------------
module stereo_axis_skid #(
   parameter int unsigned DataWidth = 96
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [DataWidth-1:0] in_data_i,
   input  logic                 in_valid_i,
   input  logic                 in_user_i,
   input  logic                 in_last_i,
   output logic                 in_ready_o,
   output logic [DataWidth-1:0] out_data_o,
   output logic                 out_valid_o,
   output logic                 out_user_o,
   output logic                 out_last_o,
   input  logic                 out_ready_i
);

   localparam int unsigned EntryW = DataWidth + 2;

   logic [EntryW-1:0] in_entry;
   logic [EntryW-1:0] head_q, head_d;
   logic [EntryW-1:0] tail_q, tail_d;
   logic [1:0]        count_q, count_d;
   logic              push, pop;

   assign in_entry   = {in_user_i, in_last_i, in_data_i};
   assign in_ready_o = (count_q != 2'd2) && !rst_i;
   assign push       = in_valid_i && in_ready_o;
   assign pop        = (count_q != 2'd0) && out_ready_i;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push && !pop) begin
         if (count_q == 2'd0) head_d = in_entry;
         else                 tail_d = in_entry;
         count_d = count_q + 2'd1;
      end else if (!push && pop) begin
         if (count_q == 2'd2) head_d = tail_q;
         count_d = count_q - 2'd1;
      end else if (push && pop) begin
         // Occupancy unchanged: the head drains, the new beat queues behind
         // whatever is left.
         if (count_q == 2'd1) begin
            head_d = in_entry;
         end else begin
            head_d = tail_q;
            tail_d = in_entry;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign out_valid_o = (count_q != 2'd0);
   assign out_user_o  = head_q[EntryW-1];
   assign out_last_o  = head_q[EntryW-2];
   assign out_data_o  = head_q[DataWidth-1:0];

endmodule

// File: rtl/stereo_axis_framer.sv
// -----------------------------------------------------------------------------
// stereo_axis_framer
// Selects one plane (left / right / disparity / ...) out of a multi-plane
// AXI4-Stream video input and replicates it into the three output components
// of every pixel, regenerating tuser/tlast from its own x/y counters and
// recovering from malformed framing.
//
// Ports
//   aclk, areset            clock, synchronous active-high reset
//   s_axis_*                input stream, SAMPLES_PER_CLOCK*CHANNELS planes
//   m_axis_*                output stream, SAMPLES_PER_CLOCK*3 components
//   switch_img              plane select, latched on each accepted tuser beat
//   frame_count             completed frames (wrapping)
//   err_count               framing errors (saturating)
//   sync_lost               sticky: a tuser arrived mid-frame
//
// Build option
//   STEREO_FRAMER_STATS_EN  when defined, frame_count / err_count / sync_lost
//                           are implemented; otherwise they are tied to 0.
// -----------------------------------------------------------------------------
module stereo_axis_framer
   import stereo_pkg::*;
#(
   parameter int unsigned WIDTH             = 3840,
   parameter int unsigned HEIGHT            = 2160,
   parameter int unsigned SAMPLES_PER_CLOCK = 4,
   parameter int unsigned CHANNELS          = 3,
   parameter int unsigned DATA_WIDTH        = 8
) (
   input  logic                                          aclk,
   input  logic                                          areset,
   input  logic [SAMPLES_PER_CLOCK*CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                                          s_axis_tvalid,
   input  logic                                          s_axis_tuser,
   input  logic                                          s_axis_tlast,
   output logic                                          s_axis_tready,
   output logic [SAMPLES_PER_CLOCK*3*DATA_WIDTH-1:0]      m_axis_tdata,
   output logic                                          m_axis_tvalid,
   output logic                                          m_axis_tuser,
   output logic                                          m_axis_tlast,
   input  logic                                          m_axis_tready,
   input  logic [3:0]                                    switch_img,
   output logic [15:0]                                   frame_count,
   output logic [7:0]                                    err_count,
   output logic                                          sync_lost
);

   localparam int unsigned BPL   = WIDTH / SAMPLES_PER_CLOCK;
   localparam int unsigned XW    = cnt_width(BPL);
   localparam int unsigned YW    = cnt_width(HEIGHT);
   localparam int unsigned PIX_W = 3 * DATA_WIDTH;
   localparam int unsigned OUT_W = SAMPLES_PER_CLOCK * PIX_W;
   localparam logic [XW-1:0] X_LAST = XW'(BPL - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

   state_e          state_q, state_d;
   logic [XW-1:0]   x_q, x_d, pos_x;
   logic [YW-1:0]   y_q, y_d, pos_y;
   logic [3:0]      sel_q, sel_d, sel_eff;
   logic            accept, fwd, line_end;
   logic [OUT_W-1:0] fwd_data;

   assign accept = s_axis_tvalid && s_axis_tready;
   // Outside a frame only a tuser beat is forwarded; everything else is dropped.
   assign fwd    = accept && ((state_q == StActive) || s_axis_tuser);

   // A tuser beat always sits at (0,0) and uses the select presented with it,
   // whether it opens a frame or resynchronises one already in progress.
   assign pos_x   = s_axis_tuser ? '0 : x_q;
   assign pos_y   = s_axis_tuser ? '0 : y_q;
   assign sel_eff = s_axis_tuser ? switch_img : sel_q;

   // Early input tlast ends the line as well as the local counter does.
   assign line_end = (pos_x == X_LAST) || s_axis_tlast;

   always_comb begin
      fwd_data = '0;
      for (int i = 0; i < int'(SAMPLES_PER_CLOCK); i++) begin
         for (int c = 0; c < int'(CHANNELS); c++) begin
            if (sel_eff == 4'(c)) begin
               fwd_data[i*PIX_W +: PIX_W] =
                  {3{s_axis_tdata[(i*CHANNELS+c)*DATA_WIDTH +: DATA_WIDTH]}};
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      sel_d   = sel_q;
      if (fwd) begin
         sel_d = sel_eff;
         if (line_end) begin
            x_d = '0;
            if (pos_y == Y_LAST) begin
               y_d     = '0;
               state_d = StWaitSof;
            end else begin
               y_d     = pos_y + YW'(1);
               state_d = StActive;
            end
         end else begin
            x_d     = pos_x + XW'(1);
            y_d     = pos_y;
            state_d = StActive;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= StWaitSof;
         x_q     <= '0;
         y_q     <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         sel_q   <= sel_d;
      end
   end

   stereo_axis_skid #(
      .DataWidth (OUT_W)
   ) u_skid (
      .clk_i       (aclk),
      .rst_i       (areset),
      .in_data_i   (fwd_data),
      .in_valid_i  (fwd),
      .in_user_i   (s_axis_tuser),
      .in_last_i   (line_end),
      .in_ready_o  (s_axis_tready),
      .out_data_o  (m_axis_tdata),
      .out_valid_o (m_axis_tvalid),
      .out_user_o  (m_axis_tuser),
      .out_last_o  (m_axis_tlast),
      .out_ready_i (m_axis_tready)
   );

`ifdef STEREO_FRAMER_STATS_EN
   logic                   line_err, resync, frame_done;
   logic [FrameCountW-1:0] frame_count_q;
   logic [ErrCountW-1:0]   err_count_q;
   logic                   sync_lost_q;

   // Mismatch between input tlast and the local line end, either direction.
   assign line_err   = fwd && ((pos_x == X_LAST) != s_axis_tlast);
   assign resync     = fwd && s_axis_tuser && (state_q == StActive) &&
                       ((x_q != '0) || (y_q != '0));
   assign frame_done = fwd && line_end && (pos_y == Y_LAST);

   always_ff @(posedge aclk) begin
      if (areset) begin
         frame_count_q <= '0;
         err_count_q   <= '0;
         sync_lost_q   <= 1'b0;
      end else begin
         if (frame_done) frame_count_q <= frame_count_q + 16'd1;
         if ((line_err || resync) && (err_count_q != ErrSat)) begin
            err_count_q <= err_count_q + 8'd1;
         end
         if (resync) sync_lost_q <= 1'b1;
      end
   end

   assign frame_count = frame_count_q;
   assign err_count   = err_count_q;
   assign sync_lost   = sync_lost_q;
`else
   assign frame_count = '0;
   assign err_count   = '0;
   assign sync_lost   = 1'b0;
`endif

endmodule

// File: tb/tb_stereo_axis_framer.sv
module tb_stereo_axis_framer;

   localparam int unsigned W   = 16;
   localparam int unsigned H   = 4;
   localparam int unsigned SPC = 4;
   localparam int unsigned CH  = 3;
   localparam int unsigned DW  = 8;
   localparam int unsigned IN_W  = SPC * CH * DW;
   localparam int unsigned OUT_W = SPC * 3 * DW;
`ifdef STEREO_FRAMER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic              aclk;
   logic              areset;
   logic [IN_W-1:0]   s_axis_tdata;
   logic              s_axis_tvalid, s_axis_tuser, s_axis_tlast, s_axis_tready;
   logic [OUT_W-1:0]  m_axis_tdata;
   logic              m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tready;
   logic [3:0]        switch_img;
   logic [15:0]       frame_count;
   logic [7:0]        err_count;
   logic              sync_lost;

   stereo_axis_framer #(
      .WIDTH             (W),
      .HEIGHT            (H),
      .SAMPLES_PER_CLOCK (SPC),
      .CHANNELS          (CH),
      .DATA_WIDTH        (DW)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .switch_img    (switch_img),
      .frame_count   (frame_count),
      .err_count     (err_count),
      .sync_lost     (sync_lost)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // One input beat and what must come out of it.
   typedef struct {
      bit         user;
      bit         last;
      logic [3:0] sel;
      bit         fwd;
      bit         eu;
      bit         el;
      int         plane;
   } vec_t;

   // Segment end index plus the stats expected once it has drained.
   typedef struct {
      int n_end;
      int frames;
      int errs;
      bit sync;
      bit stall;
   } seg_t;

   typedef struct {
      logic             u;
      logic             l;
      logic [OUT_W-1:0] d;
   } exp_t;

   vec_t vecs[$];
   seg_t segs[$];
   exp_t exp_q[$];
   exp_t me;
   int   tests = 0;
   int   fails = 0;
   int   kbeat = 0;
   bit   mon_en = 1'b0;
   bit   stall_en = 1'b0;
   int   ph = 0;
   logic [3:0] stall_pat = 4'b1001; // bit ph -> ready: 1,0,0,1

   function automatic logic [IN_W-1:0] mk_in(input int k);
      logic [IN_W-1:0] v;
      v = '0;
      for (int i = 0; i < int'(SPC); i++)
         for (int c = 0; c < int'(CH); c++)
            v[(i*CH+c)*DW +: DW] = 8'(k*13 + i*3 + c + 1);
      return v;
   endfunction

   function automatic logic [OUT_W-1:0] mk_out(input int k, input int plane);
      logic [OUT_W-1:0] v;
      logic [7:0]       b;
      v = '0;
      for (int i = 0; i < int'(SPC); i++) begin
         b = (plane >= 0 && plane < int'(CH)) ? 8'(k*13 + i*3 + plane + 1) : 8'd0;
         v[i*24 +: 24] = {b, b, b};
      end
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic add(input bit user, input bit last, input logic [3:0] sel, input bit fwd,
                      input bit eu, input bit el, input int plane);
      vec_t v;
      v.user = user; v.last = last; v.sel = sel; v.fwd = fwd;
      v.eu = eu; v.el = el; v.plane = plane;
      vecs.push_back(v);
   endtask

   task automatic add_frame(input logic [3:0] sel0, input logic [3:0] sel_rest, input int plane);
      for (int b = 0; b < 16; b++)
         add(b == 0, (b % 4) == 3, (b == 0) ? sel0 : sel_rest, 1'b1, b == 0, (b % 4) == 3, plane);
   endtask

   task automatic end_seg(input int frames, input int errs, input bit sync, input bit stall);
      seg_t s;
      s.n_end = vecs.size(); s.frames = frames; s.errs = errs; s.sync = sync; s.stall = stall;
      segs.push_back(s);
   endtask

   // Entered and left at posedge+1.
   task automatic drive(input vec_t v);
      int   n;
      exp_t e;
      s_axis_tdata  = mk_in(kbeat);
      s_axis_tuser  = v.user;
      s_axis_tlast  = v.last;
      switch_img    = v.sel;
      s_axis_tvalid = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!s_axis_tready && n < 64) begin
         @(negedge aclk);
         n++;
      end
      if (!s_axis_tready) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout beat %0d: s_axis_tready got 0, required 1", kbeat);
         @(posedge aclk);
      end else begin
         @(posedge aclk);
         if (v.fwd) begin
            e.u = v.eu; e.l = v.el; e.d = mk_out(kbeat, v.plane);
            exp_q.push_back(e);
         end
      end
      #1;
      s_axis_tvalid = 1'b0;
      kbeat++;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge aclk);
         n++;
      end
      repeat (2) @(posedge aclk);
      #1;
      chk("drain_left", exp_q.size(), 0);
   endtask

   // Downstream ready pattern for the stall segment.
   always @(posedge aclk) begin
      #1;
      if (stall_en) begin
         m_axis_tready = stall_pat[ph];
         ph = (ph + 1) % 4;
      end
   end

   // Output scoreboard, sampled mid-cycle.
   always @(negedge aclk) begin
      if (mon_en) begin
         if (stall_en) begin
            tests++;
            if (s_axis_tready !== (exp_q.size() < 2)) begin
               fails++;
               $display("FAIL s_ready_occupancy: got %0b, required %0b (held %0d)",
                        s_axis_tready, exp_q.size() < 2, exp_q.size());
            end
         end
         if (exp_q.size() > 0) begin
            tests++;
            if (m_axis_tvalid !== 1'b1) begin
               fails++;
               $display("FAIL out_valid_latency: got %0b, required 1", m_axis_tvalid);
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_beat: got valid beat user=%0b last=%0b, required none",
                        m_axis_tuser, m_axis_tlast);
            end else begin
               me = exp_q.pop_front();
               if ({m_axis_tuser, m_axis_tlast, m_axis_tdata} !== {me.u, me.l, me.d}) begin
                  fails++;
                  $display("FAIL out_beat: got u=%0b l=%0b d=%h, required u=%0b l=%0b d=%h",
                           m_axis_tuser, m_axis_tlast, m_axis_tdata, me.u, me.l, me.d);
               end
            end
         end
      end
   end

   initial begin
      int vi;
      // A: clean frame, right plane
      add_frame(4'd1, 4'd1, 1);
      end_seg(1, 0, 0, 0);
      // B: three junk beats dropped before SOF, then a left-plane frame
      add(0, 0, 4'd0, 0, 0, 0, 0);
      add(0, 1, 4'd0, 0, 0, 0, 0);
      add(0, 0, 4'd0, 0, 0, 0, 0);
      add_frame(4'd0, 4'd0, 0);
      end_seg(2, 0, 0, 0);
      // C: early tlast on beat 2 of line 1 -> 15-beat frame
      for (int b = 0; b < 15; b++)
         add(b == 0, b == 3 || b == 6 || b == 10 || b == 14, 4'd2, 1, b == 0,
             b == 3 || b == 6 || b == 10 || b == 14, 2);
      end_seg(3, 1, 0, 0);
      // D: tuser at beat 6 restarts the frame
      for (int b = 0; b < 6; b++) add(b == 0, b == 3, 4'd1, 1, b == 0, b == 3, 1);
      for (int r = 0; r < 16; r++) add(r == 0, (r % 4) == 3, 4'd1, 1, r == 0, (r % 4) == 3, 1);
      end_seg(4, 2, 1, 0);
      // E: missing input tlast at the end of line 1
      for (int b = 0; b < 16; b++)
         add(b == 0, ((b % 4) == 3) && b != 7, 4'd0, 1, b == 0, (b % 4) == 3, 0);
      end_seg(5, 3, 1, 0);
      // F: select changes only take effect at the next SOF; 5 gives zero data
      add_frame(4'd0, 4'd2, 0);
      add_frame(4'd2, 4'd5, 2);
      add_frame(4'd5, 4'd5, 5);
      end_seg(8, 3, 1, 0);
      // G: downstream ready toggling 1,0,0,1
      add_frame(4'd1, 4'd1, 1);
      end_seg(9, 3, 1, 1);

      areset = 1'b1;
      s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
      m_axis_tready = 1'b1;
      switch_img = 4'd0;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_m_valid", m_axis_tvalid, 0);
      chk("rst_m_user", m_axis_tuser, 0);
      chk("rst_m_last", m_axis_tlast, 0);
      chk("rst_m_data_zero", (m_axis_tdata == '0), 1);
      chk("rst_s_ready", s_axis_tready, 0);
      chk("rst_frame_count", frame_count, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_sync_lost", sync_lost, 0);
      areset = 1'b0;
      @(negedge aclk);
      chk("s_ready_after_rst", s_axis_tready, 1);
      @(posedge aclk);
      #1;
      mon_en = 1'b1;

      vi = 0;
      for (int s = 0; s < segs.size(); s++) begin
         stall_en = segs[s].stall;
         ph = 0;
         for (; vi < segs[s].n_end; vi++) drive(vecs[vi]);
         stall_en = 1'b0;
         m_axis_tready = 1'b1;
         drain();
         chk($sformatf("seg%0d_frame_count", s), frame_count, STATS ? segs[s].frames : 0);
         chk($sformatf("seg%0d_err_count", s), err_count, STATS ? segs[s].errs : 0);
         chk($sformatf("seg%0d_sync_lost", s), sync_lost, STATS ? segs[s].sync : 0);
      end

      // Mid-frame reset with a full buffer: everything buffered is discarded.
      mon_en = 1'b0;
      m_axis_tready = 1'b0;
      s_axis_tvalid = 1'b1; s_axis_tuser = 1'b1; s_axis_tlast = 1'b0; switch_img = 4'd1;
      s_axis_tdata = mk_in(200);
      @(posedge aclk);
      #1;
      s_axis_tuser = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      chk("prefill_full", s_axis_tready, 0);
      s_axis_tvalid = 1'b0;
      areset = 1'b1;
      @(posedge aclk);
      #1;
      chk("midrst_m_valid", m_axis_tvalid, 0);
      chk("midrst_s_ready", s_axis_tready, 0);
      chk("midrst_frame_count", frame_count, 0);
      chk("midrst_err_count", err_count, 0);
      chk("midrst_sync_lost", sync_lost, 0);
      areset = 1'b0;
      m_axis_tready = 1'b1;
      exp_q.delete();
      @(negedge aclk);
      chk("midrst_s_ready_after", s_axis_tready, 1);
      chk("midrst_no_stale", m_axis_tvalid, 0);
      @(posedge aclk);
      #1;
      mon_en = 1'b1;
      // Back in WAIT_SOF: a non-tuser beat must vanish, then a frame flows.
      begin
         vec_t v;
         v.user = 0; v.last = 0; v.sel = 4'd2; v.fwd = 0; v.eu = 0; v.el = 0; v.plane = 0;
         drive(v);
         for (int b = 0; b < 16; b++) begin
            v.user = (b == 0); v.last = (b % 4) == 3; v.sel = 4'd2; v.fwd = 1;
            v.eu = (b == 0); v.el = (b % 4) == 3; v.plane = 2;
            drive(v);
         end
      end
      drain();
      chk("post_rst_frame_count", frame_count, STATS ? 1 : 0);
      chk("post_rst_err_count", err_count, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/stereo_axis_framer.md
STEREO_AXIS_FRAMER -- requirements
Module: stereo_axis_framer

Interface
REQ-001 SHALL have parameter WIDTH, default 3840, pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 2160, lines per frame.
REQ-003 SHALL have parameter SAMPLES_PER_CLOCK, default 4, pixels per beat; WIDTH divisible by it.
REQ-004 SHALL have parameter CHANNELS, default 3, input planes per pixel (left, right, disparity), range 1..8.
REQ-005 SHALL have parameter DATA_WIDTH, default 8, bits per plane sample.
REQ-006 SHALL have ports aclk  in  1  sole clock; areset  in  1  synchronous active-high reset.
REQ-007 SHALL have ports s_axis_tdata  in  SAMPLES_PER_CLOCK*CHANNELS*DATA_WIDTH; s_axis_tvalid, s_axis_tuser (start of frame), s_axis_tlast (end of line)  in  1; s_axis_tready  out  1.
REQ-008 SHALL have ports m_axis_tdata  out  SAMPLES_PER_CLOCK*3*DATA_WIDTH; m_axis_tvalid, m_axis_tuser, m_axis_tlast  out  1; m_axis_tready  in  1.
REQ-009 SHALL have ports switch_img  in  4  plane select; frame_count  out  16  completed frames; err_count  out  8  framing errors; sync_lost  out  1  sticky resync flag.

Function
REQ-010 SHALL, per pixel, place the selected plane's sample into all 3 output components; sample i occupies in-bits [(i*CHANNELS+c)*DATA_WIDTH +: DATA_WIDTH] and out-bits [i*3*DATA_WIDTH +: 3*DATA_WIDTH].
REQ-011 SHALL latch switch_img only on an accepted tuser beat; mid-frame changes take effect next frame; latched value >= CHANNELS SHALL output all-zero data.
REQ-012 SHALL implement FSM WAIT_SOF -> ACTIVE on accepted beat with tuser=1; in WAIT_SOF beats without tuser are accepted and dropped.
REQ-013 SHALL keep beat counter x (0..WIDTH/SAMPLES_PER_CLOCK-1) and line counter y (0..HEIGHT-1) advancing only on accepted beats.
REQ-014 SHALL regenerate m_axis_tlast at x = last beat, and m_axis_tuser on the first forwarded beat of each frame, independent of input tlast.
REQ-015 SHALL, on input tlast with x not last (early), force output tlast, set x=0, advance y, increment err_count.
REQ-016 SHALL, on x last without input tlast (late), still emit output tlast, wrap x=0, increment err_count.
REQ-017 SHALL, on tuser in ACTIVE with (x,y) != (0,0), restart at x=0,y=0, forward beat with m_axis_tuser=1, increment err_count, set sync_lost.
REQ-018 SHALL, after last beat of line HEIGHT-1, increment frame_count (wrapping) and return to WAIT_SOF.
REQ-019 SHALL saturate err_count at 255; sync_lost clears only on reset.
REQ-020 SHALL buffer output in a 2-entry skid buffer: s_axis_tready = not full; latency 1 cycle from accept to m_axis_tvalid; no bubbles at full throughput; m_axis_* stable while tvalid=1 and tready=0.

Reset
REQ-021 SHALL, while areset=1 at a clock edge: FSM WAIT_SOF, x=y=0, buffer empty, m_axis_tvalid/tuser/tlast=0, m_axis_tdata=0, s_axis_tready=0, frame_count=0, err_count=0, sync_lost=0, latched select=0.
REQ-022 SHALL drive s_axis_tready=1 the first cycle after areset deasserts; reset mid-frame discards buffered beats.

Configuration
REQ-023 SHALL, with STEREO_FRAMER_STATS_EN defined, implement frame_count, err_count, sync_lost per REQ-009..REQ-019.
REQ-024 SHALL, without STEREO_FRAMER_STATS_EN, keep these ports driven constant 0 and omit their registers; framing/resync behaviour unchanged.

Structure
REQ-025 SHALL place FSM state enum, counter widths ($clog2 of beats-per-line and HEIGHT) and err_count saturation constant in shared package stereo_pkg.
REQ-026 SHALL implement the skid buffer as sub-module stereo_axis_skid, parametrised by data width plus tuser/tlast.

Verification (WIDTH=16, HEIGHT=4, SAMPLES_PER_CLOCK=4, CHANNELS=3, DATA_WIDTH=8; 4 beats/line)
REQ-027 Clean frame, switch_img=1, m_axis_tready=1 -> 16 out beats, tuser on beat 0, tlast on beats 3,7,11,15, each byte = right-plane sample, frame_count=1, err_count=0.
REQ-028 3 junk beats before tuser -> junk dropped, output starts at tuser beat, 16 beats.
REQ-029 Input tlast on beat 2 of line 1 -> output tlast on that beat, err_count=1, frame still ends after 15 accepted beats total.
REQ-030 tuser at beat 6 -> that beat has m_axis_tuser=1, counters restart, sync_lost=1, err_count=1.
REQ-031 m_axis_tready toggling 1,0,0,1 at full input rate -> no loss/duplication, s_axis_tready low only when both entries full, output data unchanged during stall.
REQ-032 switch_img 0->2 mid-frame then switch_img=5 -> current frame stays left plane, next frame disparity, third frame all-zero data.
